// File: rtl/uart_rx_sin_if.sv
// Core-side byte interface of the UART receiver: holding register plus status pulses.
interface uart_rx_sin_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    // Receiver side drives the byte and status, core drives the accept strobe.
    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun_err,
        output rx_busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun_err,
        input  rx_busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sin.sv
// 8N1 UART receiver for the uart_sin pad: 2-flop synchroniser, falling-edge start detect,
// mid-bit sampling and a one-entry holding register with valid/ready handshake.
module uart_rx_sin #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          uart_sin,
    uart_rx_sin_if.master rx
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    // The counter runs down to zero, so it is loaded with the interval minus one; this keeps
    // CLK_DIV-1 representable in $clog2(CLK_DIV) bits.
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLK_DIV / 2 - 1);
    localparam logic [CntW-1:0] BitLoad  = CntW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            prev_q, prev_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_err_q, overrun_err_d;
    logic            cnt_done;

    assign cnt_done = (cnt_q == '0);

    // Next-state logic: synchroniser shift, frame FSM, holding register and error pulses.
    always_comb begin
        sync1_d       = uart_sin;
        sync2_d       = sync1_q;
        prev_d        = sync2_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;

        if (rx_valid_q && rx.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (!sync2_q && prev_q) begin
                    cnt_d   = HalfLoad;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_done) begin
                    if (sync2_q) begin
                        // Line already back high at mid start bit: treat as a glitch.
                        state_d = StIdle;
                    end else begin
                        cnt_d     = BitLoad;
                        bit_idx_d = 3'd0;
                        state_d   = StData;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StData: begin
                if (cnt_done) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = BitLoad;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (cnt_done) begin
                    state_d = StIdle;
                    if (!sync2_q) begin
                        frame_err_d = 1'b1;
                    end else if (!rx_valid_q || rx.rx_ready) begin
                        // A consume in the same cycle frees the slot, so the new byte wins.
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; synchroniser resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign rx.rx_data     = rx_data_q;
    assign rx.rx_valid    = rx_valid_q;
    assign rx.frame_err   = frame_err_q;
    assign rx.overrun_err = overrun_err_q;
    assign rx.rx_busy     = (state_q != StIdle);

endmodule
